bin_2_bcd_seq: RTL

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one shift per clock.
- Replaces the unrolled combinational converter wherever wide inputs make the combinational depth unacceptable.
- Adds a start/ready/valid handshake, a configurable digit count, an optional signed mode and overflow detection.
- Feeds 7-segment and display-formatting logic.

---
 rtl/bin_2_bcd_seq_if.sv | 25 ++
 rtl/bin_2_bcd_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/bin_2_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master issues start/bin; the slave returns status and the BCD result.
interface bin_2_bcd_seq_if #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  ready;
    logic                  busy;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  overflow;
    logic                  valid;

    modport master (
        output start, bin,
        input  ready, busy, bcd, neg, overflow, valid
    );

    modport slave (
        input  start, bin,
        output ready, busy, bcd, neg, overflow, valid
    );
endinterface

// File: rtl/bin_2_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Optional signed input (sign + magnitude out) and overflow detection.
module bin_2_bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    bin_2_bcd_seq_if.slave  bus
);
    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [BIN_W-1:0] sr_q, sr_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             sign_q, sign_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    bcd_q, bcd_d;
    logic             neg_q, neg_d;
    logic             ovo_q, ovo_d;

    logic             is_neg;
    logic [BIN_W-1:0] mag;
    logic [AW-1:0]    adj;

    // Magnitude of -2^(BIN_W-1) wraps to itself, which is correct unsigned.
    always_comb begin
        is_neg = SIGNED && bus.bin[BIN_W-1];
        mag    = is_neg ? (~bus.bin + BIN_W'(1)) : bus.bin;
    end

    always_comb begin
        adj = acc_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        ovo_d   = ovo_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d    = mag;
                    sign_d  = is_neg;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = {adj[AW-2:0], sr_q[BIN_W-1]};
                sr_d  = {sr_q[BIN_W-2:0], 1'b0};
                ovf_d = ovf_q | adj[AW-1];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = acc_d;
                    neg_d   = sign_q;
                    ovo_d   = ovf_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            ovo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            ovo_q   <= ovo_d;
        end
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.valid    = (state_q == DONE);
    assign bus.bcd      = bcd_q;
    assign bus.neg      = neg_q;
    assign bus.overflow = ovo_q;
endmodule
